// File: rtl/qspi_ddr_sequencer.sv
// rtl/qspi_ddr_sequencer.sv - SPI/QSPI flash transaction sequencer driving per-pin DDR IO wrappers
// Command, address, dummy and data phases; read bytes rebuilt from the wrappers' delayed input pairs.
module qspi_ddr_sequencer #(
    parameter int RD_LAT   = 3,
    parameter int CS_SETUP = 1,
    parameter int CS_HOLD  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_stb,
    input  logic [7:0]  i_cmd,
    input  logic        i_has_addr,
    input  logic [23:0] i_addr,
    input  logic        i_quad,
    input  logic [3:0]  i_dummy,
    input  logic        i_rd,
    input  logic [7:0]  i_len,
    input  logic        i_wr_stb,
    input  logic [7:0]  i_wr_data,
    output logic        o_wr_ack,
    output logic        o_rd_stb,
    output logic [7:0]  o_rd_data,
    output logic        o_busy,
    output logic        o_cs_n,
    output logic [1:0]  o_sck_v,
    output logic [3:0]  o_dq_oe,
    output logic [7:0]  o_dq_v,
    input  logic [7:0]  i_dq_v
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DRAIN, S_HOLD
    } state_t;

    localparam logic [4:0] SETUP_LAST = 5'(CS_SETUP - 1);
    localparam logic [4:0] DRAIN_LAST = 5'(RD_LAT - 1);
    localparam logic [4:0] HOLD_LAST  = 5'(CS_HOLD - 1);
    localparam logic [1:0] SCK_IDLE   = 2'b11;
    localparam logic [1:0] SCK_PULSE  = 2'b01;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [7:0]         byte_q, byte_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [23:0]        addr_q, addr_d;
    logic               has_addr_q, has_addr_d;
    logic               quad_q, quad_d;
    logic [3:0]         dummy_q, dummy_d;
    logic               rd_q, rd_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         wr_q, wr_d;
    logic [3:0]         hold_oe_q, hold_dq_q;
    logic [RD_LAT-1:0]  tag_q;
    logic [7:0]         rd_sh_q;
    logic [2:0]         rd_cnt_q;
    logic [7:0]         rd_data_q;
    logic               rd_stb_q;

    logic               cs_n, wr_ack, stall, rd_sck, bit_adv;
    logic [1:0]         sck;
    logic [3:0]         oe, dq;
    logic [7:0]         wr_src;
    logic [4:0]         last_bit;
    state_t             ph_addr, ph_dummy, ph_data;
    logic [7:0]         rd_shift;
    logic               rd_done;
    logic               dq_lo_unused;

    // Phase skipping: each phase falls through to the next enabled one.
    always_comb begin
        ph_data  = (len_q != 8'd0) ? S_DATA : S_HOLD;
        ph_dummy = (dummy_q != 4'd0) ? S_DUMMY : ph_data;
        ph_addr  = has_addr_q ? S_ADDR : ph_dummy;
    end

    assign last_bit = quad_q ? 5'd1 : 5'd7;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        has_addr_d = has_addr_q;
        quad_d     = quad_q;
        dummy_d    = dummy_q;
        rd_d       = rd_q;
        len_d      = len_q;
        wr_d       = wr_q;
        cs_n       = 1'b0;
        sck        = SCK_IDLE;
        oe         = 4'h0;
        dq         = 4'h0;
        wr_ack     = 1'b0;
        stall      = 1'b0;
        rd_sck     = 1'b0;
        bit_adv    = 1'b0;
        wr_src     = wr_q;
        case (state_q)
            S_IDLE: begin
                cs_n = 1'b1;
                if (i_cmd_stb) begin
                    state_d    = S_SETUP;
                    cnt_d      = 5'd0;
                    byte_d     = 8'd0;
                    cmd_d      = i_cmd;
                    addr_d     = i_addr;
                    has_addr_d = i_has_addr;
                    quad_d     = i_quad;
                    dummy_d    = i_dummy;
                    rd_d       = i_rd;
                    len_d      = i_len;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_CMD;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_CMD: begin
                sck   = SCK_PULSE;
                oe    = 4'b0001;
                dq[0] = cmd_q[7];
                cmd_d = {cmd_q[6:0], 1'b0};
                if (cnt_q == 5'd7) begin
                    state_d = ph_addr;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_ADDR: begin
                sck = SCK_PULSE;
                if (quad_q) begin
                    oe     = 4'b1111;
                    dq     = addr_q[23:20];
                    addr_d = {addr_q[19:0], 4'h0};
                end else begin
                    oe     = 4'b0001;
                    dq[0]  = addr_q[23];
                    addr_d = {addr_q[22:0], 1'b0};
                end
                if (cnt_q == (quad_q ? 5'd5 : 5'd23)) begin
                    state_d = ph_dummy;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DUMMY: begin
                sck = SCK_PULSE;
                if (cnt_q == ({1'b0, dummy_q} - 5'd1)) begin
                    state_d = ph_data;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DATA: begin
                if (rd_q) begin
                    sck     = SCK_PULSE;
                    rd_sck  = 1'b1;
                    bit_adv = 1'b1;
                end else if (cnt_q == 5'd0 && !i_wr_stb) begin
                    // Starved write: freeze the bus exactly as last driven.
                    stall = 1'b1;
                    oe    = hold_oe_q;
                    dq    = hold_dq_q;
                end else begin
                    sck     = SCK_PULSE;
                    bit_adv = 1'b1;
                    oe      = quad_q ? 4'b1111 : 4'b0001;
                    if (cnt_q == 5'd0) begin
                        wr_ack = 1'b1;
                        wr_src = i_wr_data;
                    end
                    if (quad_q) begin
                        dq   = wr_src[7:4];
                        wr_d = {wr_src[3:0], 4'h0};
                    end else begin
                        dq[0] = wr_src[7];
                        wr_d  = {wr_src[6:0], 1'b0};
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_HOLD;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_HOLD: begin
                cs_n = 1'b1;
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bit_adv) begin
            if (cnt_q == last_bit) begin
                cnt_d = 5'd0;
                if (byte_q == len_q - 8'd1) begin
                    state_d = rd_q ? S_DRAIN : S_HOLD;
                end else begin
                    byte_d = byte_q + 8'd1;
                end
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    // Single-lane reads arrive on dq1 (MISO); quad reads use all four lanes.
    assign rd_shift = quad_q ? {rd_sh_q[3:0], i_dq_v[7], i_dq_v[5], i_dq_v[3], i_dq_v[1]}
                             : {rd_sh_q[6:0], i_dq_v[3]};
    assign rd_done  = (rd_cnt_q == (quad_q ? 3'd1 : 3'd7));
    assign dq_lo_unused = ^{i_dq_v[6], i_dq_v[4], i_dq_v[2], i_dq_v[0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            byte_q     <= 8'd0;
            cmd_q      <= 8'd0;
            addr_q     <= 24'd0;
            has_addr_q <= 1'b0;
            quad_q     <= 1'b0;
            dummy_q    <= 4'd0;
            rd_q       <= 1'b0;
            len_q      <= 8'd0;
            wr_q       <= 8'd0;
            hold_oe_q  <= 4'h0;
            hold_dq_q  <= 4'h0;
            tag_q      <= '0;
            rd_sh_q    <= 8'd0;
            rd_cnt_q   <= 3'd0;
            rd_data_q  <= 8'd0;
            rd_stb_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            has_addr_q <= has_addr_d;
            quad_q     <= quad_d;
            dummy_q    <= dummy_d;
            rd_q       <= rd_d;
            len_q      <= len_d;
            wr_q       <= wr_d;
            if (!stall) begin
                hold_oe_q <= oe;
                hold_dq_q <= dq;
            end
            tag_q    <= {tag_q[RD_LAT-2:0], rd_sck};
            rd_stb_q <= 1'b0;
            if (tag_q[RD_LAT-1]) begin
                rd_sh_q <= rd_shift;
                if (rd_done) begin
                    rd_data_q <= rd_shift;
                    rd_stb_q  <= 1'b1;
                    rd_cnt_q  <= 3'd0;
                end else begin
                    rd_cnt_q <= rd_cnt_q + 3'd1;
                end
            end
        end
    end

    assign o_busy    = (state_q != S_IDLE);
    assign o_cs_n    = cs_n;
    assign o_sck_v   = sck;
    assign o_dq_oe   = oe;
    assign o_dq_v    = {{2{dq[3]}}, {2{dq[2]}}, {2{dq[1]}}, {2{dq[0]}}};
    assign o_wr_ack  = wr_ack;
    assign o_rd_stb  = rd_stb_q;
    assign o_rd_data = rd_data_q;
endmodule

// File: tb/tb_qspi_ddr_sequencer.sv
// tb/tb_qspi_ddr_sequencer.sv - self-checking bench for qspi_ddr_sequencer
// Expected wire traces are built phase by phase from the transaction description.
module tb_qspi_ddr_sequencer;
    localparam int RD_LAT   = 3;
    localparam int CS_SETUP = 1;
    localparam int CS_HOLD  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cmd_stb, has_addr, quad, rd, wr_stb;
    logic [7:0]  cmd, len, wr_data, dq_in;
    logic [23:0] addr;
    logic [3:0]  dummy;
    logic        wr_ack, rd_stb, busy, cs_n;
    logic [7:0]  rd_data, dq_out;
    logic [1:0]  sck;
    logic [3:0]  oe;

    int n_chk  = 0;
    int n_fail = 0;

    qspi_ddr_sequencer #(.RD_LAT(RD_LAT), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_stb(cmd_stb), .i_cmd(cmd), .i_has_addr(has_addr),
        .i_addr(addr), .i_quad(quad), .i_dummy(dummy), .i_rd(rd), .i_len(len),
        .i_wr_stb(wr_stb), .i_wr_data(wr_data), .o_wr_ack(wr_ack), .o_rd_stb(rd_stb),
        .o_rd_data(rd_data), .o_busy(busy), .o_cs_n(cs_n), .o_sck_v(sck), .o_dq_oe(oe),
        .o_dq_v(dq_out), .i_dq_v(dq_in)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic        has_addr;
        logic [23:0] addr;
        logic        quad;
        logic [3:0]  dummy;
        logic        rd;
        logic [7:0]  len;
        logic [31:0] fixed;
        logic        use_fixed;
        int          gap_byte;
        int          gap_len;
        int          mid_stb;
        int          abort_at;
        int          exp_rd;
        int          exp_ack;
    } txn_t;

    // exp = {cs_n, busy, sck[1:0], oe[3:0], dq_v[7:0], wr_ack, rd_stb}
    typedef struct {
        logic        stb;
        logic [7:0]  wdata;
        logic [17:0] exp;
        logic        rdsck;
        logic [3:0]  resp;
        logic [7:0]  rdata;
    } cyc_t;

    cyc_t       eq[$];
    logic [7:0] dbuf [256];
    txn_t       vec [7];

    function automatic logic [7:0] pair(input logic [3:0] l);
        return {{2{l[3]}}, {2{l[2]}}, {2{l[1]}}, {2{l[0]}}};
    endfunction

    function automatic logic [17:0] pk(input logic cs, input logic bsy, input logic [1:0] sk,
                                       input logic [3:0] oe_v, input logic [3:0] dq_l,
                                       input logic ack, input logic stb);
        return {cs, bsy, sk, oe_v, pair(dq_l), ack, stb};
    endfunction

    function automatic cyc_t mk(input logic cs, input logic [1:0] sk,
                                input logic [3:0] oe_v, input logic [3:0] dq_l);
        cyc_t c;
        c.stb   = 1'b0;
        c.wdata = 8'h00;
        c.exp   = pk(cs, 1'b1, sk, oe_v, dq_l, 1'b0, 1'b0);
        c.rdsck = 1'b0;
        c.resp  = 4'h0;
        c.rdata = 8'h00;
        return c;
    endfunction

    function automatic logic [7:0] flash_drive(input logic [3:0] r, input logic q, input logic [7:0] noise);
        logic [7:0] v;
        v = noise;
        if (q) begin
            v[7] = r[3]; v[5] = r[2]; v[3] = r[1]; v[1] = r[0];
        end else begin
            v[3] = r[0];
        end
        return v;
    endfunction

    function automatic txn_t mk_txn(input logic [7:0] c, input logic ha, input logic [23:0] a,
                                    input logic q, input logic [3:0] dm, input logic r,
                                    input logic [7:0] l);
        txn_t t;
        t.cmd = c; t.has_addr = ha; t.addr = a; t.quad = q; t.dummy = dm; t.rd = r; t.len = l;
        t.fixed = 32'h0; t.use_fixed = 1'b0; t.gap_byte = -1; t.gap_len = 0;
        t.mid_stb = -1; t.abort_at = -1;
        t.exp_rd  = r ? int'(l) : 0;
        t.exp_ack = r ? 0 : int'(l);
        return t;
    endfunction

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Expected per-cycle wire activity from accept+1 up to and including the first idle cycle.
    task automatic build(input txn_t t);
        cyc_t        c;
        int          last_s[$];
        logic [17:0] ex;
        logic [7:0]  b;
        logic [3:0]  lanes;
        int          cpb;
        eq.delete();
        cpb = t.quad ? 2 : 8;
        for (int i = 0; i < CS_SETUP; i++) eq.push_back(mk(1'b0, 2'b11, 4'h0, 4'h0));
        for (int i = 7; i >= 0; i--) eq.push_back(mk(1'b0, 2'b01, 4'h1, {3'b000, t.cmd[i]}));
        if (t.has_addr) begin
            if (t.quad) begin
                for (int n = 5; n >= 0; n--)
                    eq.push_back(mk(1'b0, 2'b01, 4'hF, 4'(t.addr >> (4 * n))));
            end else begin
                for (int i = 23; i >= 0; i--)
                    eq.push_back(mk(1'b0, 2'b01, 4'h1, {3'b000, t.addr[i]}));
            end
        end
        for (int i = 0; i < int'(t.dummy); i++) eq.push_back(mk(1'b0, 2'b01, 4'h0, 4'h0));
        if (t.len != 8'd0) begin
            for (int j = 0; j < int'(t.len); j++) begin
                b = dbuf[j];
                if (!t.rd && j == t.gap_byte) begin
                    for (int g = 0; g < t.gap_len; g++) begin
                        ex = eq[eq.size() - 1].exp;
                        eq.push_back(mk(1'b0, 2'b11, ex[13:10], {ex[9], ex[7], ex[5], ex[3]}));
                    end
                end
                for (int s = 0; s < cpb; s++) begin
                    lanes = t.quad ? 4'(b >> (4 - 4 * s)) : {3'b000, b[7 - s]};
                    if (t.rd) begin
                        c = mk(1'b0, 2'b01, 4'h0, 4'h0);
                        c.rdsck = 1'b1;
                        c.resp  = lanes;
                    end else begin
                        c = mk(1'b0, 2'b01, t.quad ? 4'hF : 4'h1, lanes);
                        if (s == 0) begin
                            c.stb    = 1'b1;
                            c.wdata  = b;
                            c.exp[1] = 1'b1;
                        end
                    end
                    eq.push_back(c);
                end
                if (t.rd) last_s.push_back(eq.size() - 1);
            end
            if (t.rd) for (int i = 0; i < RD_LAT; i++) eq.push_back(mk(1'b0, 2'b11, 4'h0, 4'h0));
        end
        for (int i = 0; i < CS_HOLD; i++) eq.push_back(mk(1'b1, 2'b11, 4'h0, 4'h0));
        c = mk(1'b1, 2'b11, 4'h0, 4'h0);
        c.exp[16] = 1'b0;
        eq.push_back(c);
        // A byte's strobe follows its last SCK by the wrapper latency plus one register stage.
        foreach (last_s[j]) begin
            c = eq[last_s[j] + RD_LAT + 1];
            c.exp[0] = 1'b1;
            c.rdata  = dbuf[j];
            eq[last_s[j] + RD_LAT + 1] = c;
        end
    endtask

    task automatic run_txn(input string nm, input txn_t t);
        int n_rd, n_ack;
        for (int j = 0; j < 256; j++) dbuf[j] = 8'($urandom);
        if (t.use_fixed) for (int j = 0; j < 4; j++) dbuf[j] = 8'(t.fixed >> (24 - 8 * j));
        build(t);
        n_rd = 0;
        n_ack = 0;
        cmd_stb = 1'b1; cmd = t.cmd; has_addr = t.has_addr; addr = t.addr; quad = t.quad;
        dummy = t.dummy; rd = t.rd; len = t.len;
        @(posedge clk); #1;
        cmd_stb = 1'b0; cmd = 8'($urandom); has_addr = 1'($urandom); addr = 24'($urandom);
        quad = 1'($urandom); dummy = 4'($urandom); rd = 1'($urandom); len = 8'($urandom);
        for (int i = 0; i < eq.size(); i++) begin
            wr_stb  = eq[i].stb;
            wr_data = eq[i].stb ? eq[i].wdata : 8'($urandom);
            dq_in   = 8'($urandom);
            if (i >= RD_LAT && eq[i - RD_LAT].rdsck)
                dq_in = flash_drive(eq[i - RD_LAT].resp, t.quad, dq_in);
            cmd_stb = (i == t.mid_stb);
            rst     = (i == t.abort_at);
            @(negedge clk);
            chk(nm, i, {14'b0, cs_n, busy, sck, oe, dq_out, wr_ack, rd_stb}, {14'b0, eq[i].exp});
            if (rd_stb) n_rd++;
            if (wr_ack) n_ack++;
            if (eq[i].exp[0]) chk({nm, "_rdata"}, i, {24'b0, rd_data}, {24'b0, eq[i].rdata});
            @(posedge clk); #1;
            if (i == t.abort_at) begin
                cmd_stb = 1'b0; rst = 1'b0; wr_stb = 1'b0;
                for (int k = 0; k < RD_LAT + 3; k++) begin
                    @(negedge clk);
                    chk({nm, "_abort_idle"}, k, {14'b0, cs_n, busy, sck, oe, dq_out, wr_ack, rd_stb},
                        {14'b0, pk(1'b1, 1'b0, 2'b11, 4'h0, 4'h0, 1'b0, 1'b0)});
                    chk({nm, "_abort_rdata"}, k, {24'b0, rd_data}, 32'h0);
                    @(posedge clk); #1;
                end
                return;
            end
        end
        cmd_stb = 1'b0;
        wr_stb  = 1'b0;
        if (t.exp_rd >= 0) chk({nm, "_rd_count"}, 0, n_rd, t.exp_rd);
        if (t.exp_ack >= 0) chk({nm, "_ack_count"}, 0, n_ack, t.exp_ack);
    endtask

    initial begin
        txn_t t;
        rst = 1'b1; cmd_stb = 1'b0; cmd = 8'h0; has_addr = 1'b0; addr = 24'h0; quad = 1'b0;
        dummy = 4'h0; rd = 1'b0; len = 8'h0; wr_stb = 1'b0; wr_data = 8'h0; dq_in = 8'h0;

        vec[0] = mk_txn(8'h9F, 1'b0, 24'h0, 1'b0, 4'd0, 1'b1, 8'd3);
        vec[0].use_fixed = 1'b1; vec[0].fixed = 32'hEF4018_00; vec[0].exp_rd = 3; vec[0].exp_ack = 0;
        vec[1] = mk_txn(8'h6B, 1'b1, 24'h123456, 1'b1, 4'd8, 1'b1, 8'd4);
        vec[1].exp_rd = 4; vec[1].exp_ack = 0;
        vec[2] = mk_txn(8'h02, 1'b1, 24'h000000, 1'b0, 4'd0, 1'b0, 8'd2);
        vec[2].gap_byte = 1; vec[2].gap_len = 5; vec[2].exp_rd = 0; vec[2].exp_ack = 2;
        vec[3] = mk_txn(8'h06, 1'b0, 24'h0, 1'b0, 4'd0, 1'b0, 8'd0);
        vec[3].mid_stb = 4; vec[3].exp_rd = 0; vec[3].exp_ack = 0;
        vec[4] = mk_txn(8'h32, 1'b1, 24'hABCDEF, 1'b1, 4'd0, 1'b0, 8'd255);
        vec[4].gap_byte = 0; vec[4].gap_len = 2; vec[4].exp_rd = 0; vec[4].exp_ack = 255;
        vec[5] = mk_txn(8'h0B, 1'b1, 24'h800001, 1'b0, 4'd15, 1'b1, 8'd1);
        vec[5].exp_rd = 1; vec[5].exp_ack = 0;
        vec[6] = mk_txn(8'hEB, 1'b1, 24'h00FF00, 1'b1, 4'd1, 1'b1, 8'd255);
        vec[6].exp_rd = 255; vec[6].exp_ack = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 0, {14'b0, cs_n, busy, sck, oe, dq_out, wr_ack, rd_stb},
            {14'b0, pk(1'b1, 1'b0, 2'b11, 4'h0, 4'h0, 1'b0, 1'b0)});
        chk("reset_rdata", 0, {24'b0, rd_data}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vec[v]) run_txn($sformatf("vec%0d", v), vec[v]);

        t = vec[1];
        t.abort_at = 26;
        t.exp_rd = -1;
        t.exp_ack = -1;
        run_txn("abort_quad_rd", t);
        run_txn("after_abort", vec[0]);

        for (int r = 0; r < 30; r++) begin
            t = mk_txn(8'($urandom), 1'($urandom), 24'($urandom), 1'($urandom),
                       4'($urandom_range(0, 9)), 1'($urandom), 8'($urandom_range(0, 6)));
            t.gap_byte = int'($urandom_range(0, 5));
            t.gap_len  = int'($urandom_range(0, 3));
            t.mid_stb  = int'($urandom_range(1, 8));
            run_txn($sformatf("rand%0d", r), t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
